muldiv_ctrl: RTL

Sequencer for the shared iterative multiply/divide datapath of the RV64 core. It sits beside the execute stage and accepts one M-extension operation at a time, with operands already forwarded and signedness flags decoded. It runs a radix-2 shift-add multiply or restoring divide over multiple cycles and stalls the pipeline while busy. It then presents low/high (quotient/remainder) results for one cycle and returns to idle.

---
 rtl/muldiv_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative multiply/divide sequencer for the RV64 execute stage
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            muldiv_req_valid_i,
  input  logic            muldiv_mul_en_i,
  input  logic            muldiv_word_i,
  input  logic [XLEN-1:0] muldiv_rs1_data_i,
  input  logic [XLEN-1:0] muldiv_rs2_data_i,
  input  logic            muldiv_rs1_sign_i,
  input  logic            muldiv_rs2_sign_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] muldiv_data_1_o,
  output logic [XLEN-1:0] muldiv_data_2_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t state, state_next;

  logic            op_mul;
  logic            op_word;
  logic            neg_lo;     // product / quotient sign
  logic            neg_hi;     // remainder sign
  logic [CW-1:0]   count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // accept-cycle operand decode: extension, magnitudes and special cases
  logic            accept;
  logic [XLEN-1:0] op1, op2, mag1, mag2, min_val, dz_rem;
  logic            s1neg, s2neg, div_zero, div_ovf;

  always_comb begin
    accept   = (state == IDLE) & muldiv_req_valid_i & ~flush_i;
    op1      = muldiv_rs1_data_i;
    op2      = muldiv_rs2_data_i;
    min_val  = {1'b1, {(XLEN-1){1'b0}}};
    dz_rem   = muldiv_rs1_data_i;
    if (muldiv_word_i) begin
      op1     = muldiv_rs1_sign_i ? sext32(muldiv_rs1_data_i[31:0])
                                  : {{(XLEN-32){1'b0}}, muldiv_rs1_data_i[31:0]};
      op2     = muldiv_rs2_sign_i ? sext32(muldiv_rs2_data_i[31:0])
                                  : {{(XLEN-32){1'b0}}, muldiv_rs2_data_i[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      dz_rem  = sext32(muldiv_rs1_data_i[31:0]);
    end
    s1neg    = muldiv_rs1_sign_i & op1[XLEN-1];
    s2neg    = muldiv_rs2_sign_i & op2[XLEN-1];
    mag1     = s1neg ? -op1 : op1;
    mag2     = s2neg ? -op2 : op2;
    div_zero = ~muldiv_mul_en_i & (op2 == '0);
    div_ovf  = ~muldiv_mul_en_i & muldiv_rs1_sign_i & muldiv_rs2_sign_i &
               (op1 == min_val) & (op2 == '1);
  end

  // one restoring-divide step: shift in next dividend bit, trial subtract
  logic [XLEN:0]   div_tmp;
  logic            div_ge;
  logic [XLEN-1:0] rem_next, quo_next;

  always_comb begin
    div_tmp  = {rem, quo[XLEN-1]};
    div_ge   = (div_tmp >= {1'b0, dvs});
    rem_next = div_ge ? (div_tmp[XLEN-1:0] - dvs) : div_tmp[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], div_ge};
  end

  // sign fix-up and word sign extension of the final results
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_1, res_2;

  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -quo : quo;
    rem_fix  = neg_hi ? -rem : rem;
    if (op_mul) begin
      res_1 = op_word ? sext32(prod_fix[31:0]) : prod_fix[XLEN-1:0];
      res_2 = op_word ? '0 : prod_fix[2*XLEN-1:XLEN];
    end else begin
      res_1 = op_word ? sext32(quo_fix[31:0]) : quo_fix;
      res_2 = op_word ? sext32(rem_fix[31:0]) : rem_fix;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state, stall and done; flush overrides everything but reset
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o    = 1'b1;
          state_next = (div_zero | div_ovf) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (count == CW'(1)) state_next = FIX;
      end
      FIX: begin
        stall_o    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next = IDLE;
      done_o     = 1'b0;
    end
  end

  // datapath: latch on accept, iterate in BUSY, register results in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      op_mul          <= 1'b0;
      op_word         <= 1'b0;
      neg_lo          <= 1'b0;
      neg_hi          <= 1'b0;
      count           <= '0;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      rem             <= '0;
      quo             <= '0;
      dvs             <= '0;
      muldiv_data_1_o <= '0;
      muldiv_data_2_o <= '0;
    end else if (accept) begin
      op_mul  <= muldiv_mul_en_i;
      op_word <= muldiv_word_i;
      neg_lo  <= s1neg ^ s2neg;
      neg_hi  <= muldiv_mul_en_i ? (s1neg ^ s2neg) : s1neg;
      count   <= muldiv_word_i ? CW'(32) : CW'(XLEN);
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, mag1};
      mplier  <= mag2;
      rem     <= '0;
      // word dividends sit in the top half so 32 shifts consume them fully
      quo     <= muldiv_word_i ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
      dvs     <= mag2;
      if (div_zero) begin
        muldiv_data_1_o <= '1;
        muldiv_data_2_o <= dz_rem;
      end else if (div_ovf) begin
        muldiv_data_1_o <= op1;
        muldiv_data_2_o <= '0;
      end
    end else if (!flush_i) begin
      if (state == BUSY) begin
        count <= count - CW'(1);
        if (op_mul) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          rem <= rem_next;
          quo <= quo_next;
        end
      end else if (state == FIX) begin
        muldiv_data_1_o <= res_1;
        muldiv_data_2_o <= res_2;
      end
    end
  end

endmodule
